// File: rtl/word_to_byte_serializer_pkg.sv
// Shared definitions for the word-to-byte serializer and its deserializer peer.
package word_to_byte_serializer_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int         BYTES_PER_WORD    = 4;
  localparam int         WORD_W            = 8 * BYTES_PER_WORD;
  localparam logic [1:0] LAST_BYTE         = 2'(BYTES_PER_WORD - 1);
  // Comma-style idle character, also expected by the deserializer.
  localparam logic [7:0] DEFAULT_IDLE_BYTE = 8'hBC;

endpackage

// File: rtl/word_to_byte_serializer_if.sv
// Word-in / byte-out bus of the serializer, plus lane status.
interface word_to_byte_serializer_if;
  import word_to_byte_serializer_pkg::*;

  logic [WORD_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        data_out;
  logic              out_valid;
  logic              active;
  logic              align_err;

  // master: word source / byte-lane observer
  modport master (
    output in_data, in_valid,
    input  in_ready, data_out, out_valid, active, align_err
  );

  // slave: the serializer itself
  modport slave (
    input  in_data, in_valid,
    output in_ready, data_out, out_valid, active, align_err
  );

endinterface

// File: rtl/word_to_byte_serializer_phase_edge_detect.sv
// Rising-edge detector on the sampled clk_1 phase reference.
module phase_edge_detect (
  input  logic clk_in,
  input  logic reset_L,
  input  logic clk_1_phase,
  output logic phase_edge
);

  logic phase_q;

  // Previous phase sample; resets high so a phase already high out of reset is not an edge.
  always_ff @(posedge clk_in) begin
    if (!reset_L) phase_q <= 1'b1;
    else          phase_q <= clk_1_phase;
  end

  assign phase_edge = clk_1_phase & ~phase_q;

endmodule

// File: rtl/word_to_byte_serializer.sv
// Serializes one 32-bit word per clk_1 period into 4 bytes (MSB first) on the
// clk_4 domain, idling with IDLE_BYTE, tracking lane activity and word alignment.
module word_to_byte_serializer
  import word_to_byte_serializer_pkg::*;
#(
  parameter logic [7:0]  IDLE_BYTE    = DEFAULT_IDLE_BYTE,
  parameter int unsigned ACTIVE_WORDS = 4
) (
  input  logic                             clk_in,
  input  logic                             reset_L,
  input  logic                             clk_1_phase,
  word_to_byte_serializer_if.slave         bus
);

  localparam logic [3:0] ACTIVE_CNT = 4'(ACTIVE_WORDS);

  logic              phase_edge;
  logic              accept;
  logic              mid_word;
  state_e            state_q;
  logic [1:0]        byte_cnt_q;
  logic [WORD_W-1:0] shift_q;
  logic [7:0]        data_q;
  logic              valid_q;
  logic              err_q;
  logic [3:0]        word_cnt_q;
  logic [3:0]        word_cnt_inc;
  logic              active_q;

  phase_edge_detect u_edge (
    .clk_in      (clk_in),
    .reset_L     (reset_L),
    .clk_1_phase (clk_1_phase),
    .phase_edge  (phase_edge)
  );

  // No buffering: ready only on the phase edge, the word is taken or lost.
  assign accept       = phase_edge & bus.in_valid;
  // Bytes of the current word are still waiting to be shown.
  assign mid_word     = (state_q == SEND) && (byte_cnt_q != LAST_BYTE);
  assign word_cnt_inc = (word_cnt_q >= ACTIVE_CNT) ? word_cnt_q : word_cnt_q + 4'd1;

  // Byte FSM: load on accept, shift while bytes remain, otherwise fall back to idle.
  always_ff @(posedge clk_in) begin
    if (!reset_L) begin
      state_q    <= IDLE;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      data_q     <= IDLE_BYTE;
      valid_q    <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      // An edge that lands before the last byte drops the rest of the word.
      err_q <= phase_edge & mid_word;
      if (accept) begin
        state_q    <= SEND;
        byte_cnt_q <= '0;
        data_q     <= bus.in_data[WORD_W-1 -: 8];
        shift_q    <= bus.in_data << 8;
        valid_q    <= 1'b1;
      end else if (!phase_edge && mid_word) begin
        byte_cnt_q <= byte_cnt_q + 2'd1;
        data_q     <= shift_q[WORD_W-1 -: 8];
        shift_q    <= shift_q << 8;
      end else begin
        // Last byte done with no new word (or late phase), or edge without data.
        state_q    <= IDLE;
        byte_cnt_q <= '0;
        data_q     <= IDLE_BYTE;
        valid_q    <= 1'b0;
      end
    end
  end

  // Run length of cleanly aligned words; active once the run is long enough.
  always_ff @(posedge clk_in) begin
    if (!reset_L) begin
      word_cnt_q <= '0;
      active_q   <= 1'b0;
    end else if (phase_edge) begin
      if (!bus.in_valid) begin
        word_cnt_q <= '0;
        active_q   <= 1'b0;
      end else if (mid_word) begin
        // Misaligned word starts a fresh run.
        word_cnt_q <= 4'd1;
        active_q   <= 1'b0;
      end else begin
        word_cnt_q <= word_cnt_inc;
        active_q   <= (word_cnt_inc >= ACTIVE_CNT);
      end
    end
  end

  assign bus.in_ready  = phase_edge;
  assign bus.data_out  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.active    = active_q;
  assign bus.align_err = err_q;

endmodule

// File: tb/tb_word_to_byte_serializer.sv
// Directed + randomized bench; the reference keeps a queue of bytes still owed
// to the lane and a run length of aligned words.
module tb_word_to_byte_serializer;

  localparam logic [7:0] IDLE_B  = 8'hBC;
  localparam int         ACT_W   = 4;

  logic clk_in = 1'b0;
  logic reset_L;
  logic phase;

  word_to_byte_serializer_if bus ();

  word_to_byte_serializer #(
    .IDLE_BYTE    (IDLE_B),
    .ACTIVE_WORDS (ACT_W)
  ) dut (
    .clk_in      (clk_in),
    .reset_L     (reset_L),
    .clk_1_phase (phase),
    .bus         (bus)
  );

  always #5 clk_in = ~clk_in;

  int n_checks = 0;
  int n_pass   = 0;

  // reference state
  logic       prev_ph = 1'b1;
  logic [7:0] pend[$];
  int         run     = 0;
  logic [7:0] e_data  = IDLE_B;
  logic       e_vld   = 1'b0;
  logic       e_act   = 1'b0;
  logic       e_err   = 1'b0;

  // observation log
  logic [7:0] log_q[$];
  logic [7:0] exp_q[$];
  int         err_seen   = 0;
  int         ready_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic clear_log();
    log_q.delete();
    err_seen   = 0;
    ready_seen = 0;
  endtask

  task automatic chk_log(input string tag);
    chk({tag, "_len"}, log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk(tag, log_q[i], exp_q[i]);
  endtask

  // One clk_in cycle: drive, check in_ready, clock, update reference, check outputs.
  task automatic cycle(input logic ph, input logic v, input logic [31:0] d);
    logic edge_e, mis;
    phase        = ph;
    bus.in_valid = v;
    bus.in_data  = d;
    #1;
    edge_e = ph & ~prev_ph;
    chk("in_ready", bus.in_ready, edge_e);
    if (bus.in_ready === 1'b1) ready_seen++;
    @(posedge clk_in);
    if (!reset_L) begin
      prev_ph = 1'b1;
      pend.delete();
      run    = 0;
      e_data = IDLE_B;
      e_vld  = 1'b0;
      e_act  = 1'b0;
      e_err  = 1'b0;
    end else begin
      mis   = edge_e && (pend.size() != 0);
      e_err = mis;
      if (edge_e) begin
        pend.delete();
        if (v) for (int b = 0; b < 4; b++) pend.push_back(d[31-8*b -: 8]);
        if (!v || mis) begin
          run   = v ? 1 : 0;
          e_act = 1'b0;
        end else begin
          if (run < ACT_W) run++;
          e_act = (run >= ACT_W);
        end
      end
      if (pend.size() != 0) begin
        e_data = pend.pop_front();
        e_vld  = 1'b1;
      end else begin
        e_data = IDLE_B;
        e_vld  = 1'b0;
      end
      prev_ph = ph;
    end
    #1;
    chk("data_out",  bus.data_out,  e_data);
    chk("out_valid", bus.out_valid, e_vld);
    chk("active",    bus.active,    e_act);
    chk("align_err", bus.align_err, e_err);
    if (bus.out_valid === 1'b1) log_q.push_back(bus.data_out);
    if (bus.align_err === 1'b1) err_seen++;
  endtask

  // Nominal clk_1 period: low, low, high (edge, word offered), high.
  task automatic period(input logic v, input logic [31:0] d);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, v, d);
    cycle(1'b1, 1'b0, 32'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset_L      = 1'b0;
    phase        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data  = '0;

    // reset state
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    chk("rst_data",  bus.data_out,  IDLE_B);
    chk("rst_valid", bus.out_valid, 1'b0);
    chk("rst_active", bus.active,   1'b0);
    chk("rst_err",   bus.align_err, 1'b0);
    reset_L = 1'b1;

    // idle at startup: 10 periods, one ready pulse each, no payload
    clear_log();
    for (int p = 0; p < 10; p++) period(1'b0, 32'h0);
    chk("idle_ready_pulses", ready_seen, 10);
    chk("idle_payload", log_q.size(), 0);

    // back-to-back words then a gap
    clear_log();
    period(1'b1, 32'hDEADBEEF);
    period(1'b1, 32'h01234567);
    period(1'b0, 32'h0);
    period(1'b0, 32'h0);
    exp_q = {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
    chk_log("b2b_bytes");
    chk("b2b_align_err", err_seen, 0);
    chk("gap_active", bus.active, 1'b0);

    // activity: 4 consecutive words raise active the cycle after the 4th accept
    period(1'b1, $urandom);
    period(1'b1, $urandom);
    period(1'b1, $urandom);
    chk("act_after_3", bus.active, 1'b0);
    period(1'b1, $urandom);
    chk("act_after_4", bus.active, 1'b1);
    period(1'b0, 32'h0);
    chk("act_drop", bus.active, 1'b0);

    // misalignment while active
    for (int p = 0; p < 4; p++) period(1'b1, $urandom);
    chk("act_before_mis", bus.active, 1'b1);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    clear_log();
    cycle(1'b1, 1'b1, 32'h11223344);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'hCAFEF00D);
    chk("mis_err_pulse", bus.align_err, 1'b1);
    chk("mis_active", bus.active, 1'b0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b1, 1'b0, 32'h0);
    exp_q = {8'h11, 8'h22, 8'hCA, 8'hFE, 8'hF0, 8'h0D};
    chk_log("mis_bytes");
    chk("mis_err_count", err_seen, 1);

    // reset mid-word with phase held high
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'hA5A55A5A);
    cycle(1'b1, 1'b0, 32'h0);
    reset_L = 1'b0;
    cycle(1'b1, 1'b0, 32'h0);
    reset_L = 1'b1;
    chk("mid_rst_data",   bus.data_out,  IDLE_B);
    chk("mid_rst_valid",  bus.out_valid, 1'b0);
    chk("mid_rst_active", bus.active,    1'b0);
    chk("mid_rst_err",    bus.align_err, 1'b0);
    clear_log();
    cycle(1'b1, 1'b1, 32'hFFFF0000);
    chk("no_false_edge", ready_seen, 0);
    chk("no_false_accept", bus.out_valid, 1'b0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b1, 1'b1, 32'h5A6B7C8D);
    chk("post_rst_byte0", bus.data_out, 8'h5A);
    cycle(1'b1, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);
    cycle(1'b0, 1'b0, 32'h0);

    // randomized: nominal phase with occasional glitches, random data/valid/reset
    for (int c = 0; c < 400; c++) begin
      logic ph;
      ph = ((c % 4) >= 2);
      if ($urandom_range(9) == 0) ph = ~ph;
      reset_L = ($urandom_range(79) != 0);
      cycle(ph, ($urandom_range(3) != 0), $urandom);
    end
    reset_L = 1'b1;
    period(1'b0, 32'h0);
    period(1'b0, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/word_to_byte_serializer.md
Name: word_to_byte_serializer

Overview:
- Downstream consumer of the clock generator's outputs.
- Clocked by the clk_4 output and uses the clk_1 output as a sampled phase reference, so word and byte rates stay locked: one 32-bit word per clk_1 period becomes 4 bytes per word, MSB first.
- Drives the byte lane toward the parallel-to-serial stage.
- Emits an idle character when no word is available and reports lane activity and alignment faults.

Parameters:
- IDLE_BYTE, 8'hBC, byte driven on data_out whenever out_valid=0.
- ACTIVE_WORDS, 4, consecutive accepted words required before active asserts (range 1..15).

Ports:
- clk_in  input  1  fast clock (clk_4 output of the clock generator); all logic on rising edge.
- reset_L  input  1  synchronous, active-low reset.
- clk_1_phase  input  1  clk_1 output of the clock generator, sampled as data; same source, no synchronizer.
- in_data  input  32  word to serialize.
- in_valid  input  1  in_data holds a word.
- in_ready  output  1  word accepted this cycle (combinational).
- data_out  output  8  byte lane, registered.
- out_valid  output  1  data_out carries payload, registered.
- active  output  1  lane carrying continuous traffic, registered.
- align_err  output  1  one-cycle pulse: word boundary arrived mid-word, registered.

Behaviour:
- Reset (reset_L=0 at a clk_in edge):
  - data_out=IDLE_BYTE, out_valid=0, active=0, align_err=0.
  - byte_cnt=0, word_cnt=0, state=IDLE.
  - phase_q=1, so a high clk_1_phase right after reset does not produce a false edge.
- Edge detect:
  - phase_q registers clk_1_phase every cycle.
  - edge = clk_1_phase & ~phase_q (combinational).
  - With the nominal generator, edge occurs once per 4 clk_in cycles.
- in_ready = edge; a word is accepted iff edge & in_valid. No buffering: a word not accepted at an edge is not held by this block.
- States: IDLE, SEND.
- Accept at cycle E:
  - Next state SEND; shift register loads in_data.
  - Cycles E+1..E+4: data_out = in_data[31:24], [23:16], [15:8], [7:0]; out_valid=1 on each.
  - byte_cnt = 0..3 on those cycles.
- SEND, byte_cnt=3 (last byte on output):
  - edge & in_valid: load the next word; its byte 0 appears the following cycle, giving gapless output.
  - edge & ~in_valid: go to IDLE; next cycle data_out=IDLE_BYTE, out_valid=0.
  - no edge: go to IDLE (late phase); idle byte until the next accepted edge.
- SEND, byte_cnt<3, edge (misalignment):
  - Discard the remaining bytes.
  - Pulse align_err=1 on the next cycle.
  - If in_valid, load the new word; its byte 0 appears next cycle. Otherwise go to IDLE.
- IDLE:
  - data_out=IDLE_BYTE, out_valid=0.
  - edge & in_valid -> SEND as above.
- Activity tracking (word_cnt is 4-bit, saturating at ACTIVE_WORDS):
  - Each accept without misalignment increments word_cnt.
  - active=1 once word_cnt reaches ACTIVE_WORDS; it is registered, so active rises the cycle after the qualifying accept.
  - edge & ~in_valid, or any misalignment, clears word_cnt and active on the next cycle.
  - A misaligned accept counts as word 1 of a new run.
- Reset mid-word: the next cycle shows reset values; partial bytes are lost and no align_err is raised.
- Width rules: byte_cnt is 2 bits and never wraps past 3 inside SEND. The shift register is 32 bits and shifts left by 8.

Decomposition:
- Shared package holds:
  - state encoding (IDLE=1'b0, SEND=1'b1);
  - BYTES_PER_WORD=4;
  - default IDLE_BYTE constant, shared with the deserializer.
- One natural sub-module, phase_edge_detect: phase_q register with reset-to-1 and edge output.
- Counters and FSM stay in the top module.

Test Plan:
- Back-to-back words: in_valid=1 with words 32'hDEADBEEF then 32'h01234567 at consecutive edges.
  - data_out = DE,AD,BE,EF,01,23,45,67 on contiguous cycles, out_valid=1 throughout.
  - align_err never asserts.
- Gap: valid word, then in_valid=0 at the next edge.
  - After the 4 bytes, data_out=8'hBC and out_valid=0 for 4 cycles.
  - active stays 0, and word_cnt is 0.
- Activity: 4 consecutive valid words with ACTIVE_WORDS=4.
  - active rises the cycle after the 4th accept.
  - A later edge with in_valid=0 drops active the next cycle.
- Misalignment: force a clk_1_phase rising edge 2 cycles after an accept, with in_valid=1 and word 32'hCAFEF00D.
  - Only 2 bytes of the old word appear, then CA,FE,F0,0D.
  - align_err pulses once; active clears.
- Reset: reset_L=0 for one cycle mid-word while clk_1_phase=1.
  - Next cycle: data_out=8'hBC, out_valid=0, active=0, align_err=0.
  - No false edge occurs until clk_1_phase goes low then high.
- Idle at startup: in_valid=0 for 10 clk_1 periods.
  - data_out=8'hBC constantly, out_valid=0, in_ready pulses once per period.
